// File: rtl/pulse_delay_meter.sv
// pulse_delay_meter: measures trigger-to-response delay and response high time.
// Define PULSE_METER_SYNC_EN to pass start_in/sig_in through 2-flop synchronizers.
module pulse_delay_meter #(
  parameter int COUNT_WIDTH = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_in,
  input  logic                   sig_in,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_flag,
  output logic [COUNT_WIDTH-1:0] delay_out,
  output logic [COUNT_WIDTH-1:0] width_out
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SIG,
    MEAS_WIDTH,
    REPORT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_TIMEOUT = COUNT_WIDTH'(TIMEOUT);

  // bit 0 = start_in, bit 1 = sig_in
  logic [1:0] raw_in;
  logic [1:0] clean_in;
  logic [1:0] prev_reg;
  logic [1:0] rise;

  assign raw_in = {sig_in, start_in};

`ifdef PULSE_METER_SYNC_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign clean_in[gi] = sync_reg;
    end
  endgenerate
`else
  assign clean_in = raw_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_reg <= 2'b00;
    end else begin
      prev_reg <= clean_in;
    end
  end

  assign rise = clean_in & ~prev_reg;

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] delay_cnt_reg, delay_cnt_next;
  logic [COUNT_WIDTH-1:0] width_cnt_reg, width_cnt_next;
  logic [COUNT_WIDTH-1:0] delay_out_reg, delay_out_next;
  logic [COUNT_WIDTH-1:0] width_out_reg, width_out_next;
  logic                   timeout_reg, timeout_next;
  logic                   done_reg, done_next;
  logic                   busy_reg, busy_next;
  logic [COUNT_WIDTH-1:0] delay_step;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      delay_cnt_reg <= '0;
      width_cnt_reg <= '0;
      delay_out_reg <= '0;
      width_out_reg <= '0;
      timeout_reg   <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      delay_cnt_reg <= delay_cnt_next;
      width_cnt_reg <= width_cnt_next;
      delay_out_reg <= delay_out_next;
      width_out_reg <= width_out_next;
      timeout_reg   <= timeout_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    delay_cnt_next = delay_cnt_reg;
    width_cnt_next = width_cnt_reg;
    delay_out_next = delay_out_reg;
    width_out_next = width_out_reg;
    timeout_next   = timeout_reg;
    done_next      = 1'b0;
    delay_step     = delay_cnt_reg + CNT_ONE;

    case (state_reg)
      IDLE: begin
        if (rise[0]) begin
          state_next     = WAIT_SIG;
          delay_cnt_next = '0;
        end
      end
      WAIT_SIG: begin
        delay_cnt_next = delay_step;
        // A response landing exactly on the timeout edge still counts as a response.
        if (rise[1]) begin
          state_next     = MEAS_WIDTH;
          width_cnt_next = CNT_ONE;
        end else if (delay_step == CNT_TIMEOUT) begin
          state_next     = REPORT;
          delay_out_next = CNT_TIMEOUT;
          width_out_next = '0;
          timeout_next   = 1'b1;
          done_next      = 1'b1;
        end
      end
      MEAS_WIDTH: begin
        if (clean_in[1]) begin
          if (width_cnt_reg != CNT_MAX) begin
            width_cnt_next = width_cnt_reg + CNT_ONE;
          end
        end else begin
          state_next     = REPORT;
          delay_out_next = delay_cnt_reg;
          width_out_next = width_cnt_reg;
          timeout_next   = 1'b0;
          done_next      = 1'b1;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == WAIT_SIG) || (state_next == MEAS_WIDTH);
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign timeout_flag = timeout_reg;
  assign delay_out    = delay_out_reg;
  assign width_out    = width_out_reg;

endmodule

// File: tb/tb_pulse_delay_meter.sv
// Bench for pulse_delay_meter: two instances (8-bit/200 and 4-bit/12) share one
// stimulus stream; expectations come from a scan-based model of the measurement rules.
module tb_pulse_delay_meter;

  localparam int NE = 4000;
`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start_in;
  logic       sig_in;
  logic       busy0, done0, to0;
  logic [7:0] dly0, wid0;
  logic       busy1, done1, to1;
  logic [3:0] dly1, wid1;

  bit raw_start [NE];
  bit raw_sig   [NE];
  bit rst_low   [NE];
  bit exp_busy  [2][NE];
  bit exp_done  [2][NE];
  bit exp_to    [2][NE];
  int exp_dly   [2][NE];
  int exp_wid   [2][NE];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int d;
    int e;
    int dly;
    int wid;
    int to;
  } pin_t;
  pin_t pins [$];

  always #5 clk = ~clk;

  pulse_delay_meter #(.COUNT_WIDTH(8), .TIMEOUT(200)) dut0 (
    .clk(clk), .reset(reset), .start_in(start_in), .sig_in(sig_in),
    .busy(busy0), .done(done0), .timeout_flag(to0),
    .delay_out(dly0), .width_out(wid0)
  );

  pulse_delay_meter #(.COUNT_WIDTH(4), .TIMEOUT(12)) dut1 (
    .clk(clk), .reset(reset), .start_in(start_in), .sig_in(sig_in),
    .busy(busy1), .done(done1), .timeout_flag(to1),
    .delay_out(dly1), .width_out(wid1)
  );

  // Input value the measurement logic sees at edge e (after optional synchronizer).
  function automatic bit eff(input bit is_sig, input int e);
    if (e < LAT) return 1'b0;
    for (int k = e - LAT; k < e; k++) if (rst_low[k]) return 1'b0;
    return is_sig ? raw_sig[e - LAT] : raw_start[e - LAT];
  endfunction

  function automatic bit rise(input bit is_sig, input int e);
    bit p;
    p = (e >= 1 && !rst_low[e - 1]) ? eff(is_sig, e - 1) : 1'b0;
    return eff(is_sig, e) && !p;
  endfunction

  task automatic put(input int d, input int e, input bit b, input bit dn,
                     input int dl, input int wd, input bit t);
    exp_busy[d][e] = b;
    exp_done[d][e] = dn;
    exp_dly[d][e]  = dl;
    exp_wid[d][e]  = wd;
    exp_to[d][e]   = t;
  endtask

  // For each accepted trigger, scan forward for the response and its length.
  task automatic run_model(input int d, input int cw, input int tmo);
    int od, ow, e, e0, t, n, w, stop, maxv;
    bit ot, skip;
    maxv = (1 << cw) - 1;
    od = 0; ow = 0; ot = 0; e = 0; skip = 0;
    while (e < NE) begin
      if (rst_low[e]) begin
        od = 0; ow = 0; ot = 0; skip = 0;
        put(d, e, 0, 0, 0, 0, 0);
        e++;
      end else if (skip || !rise(0, e)) begin
        put(d, e, 0, 0, od, ow, ot);
        skip = 0;
        e++;
      end else begin
        e0 = e; n = 0; w = 0; t = e0 + 1; stop = 0;
        while (stop == 0) begin
          if (t >= NE || rst_low[t]) stop = 2;
          else if (rise(1, t)) begin n = t - e0; stop = 1; end
          else if (t - e0 == tmo) stop = 1;
          else t++;
        end
        if (stop == 1 && n > 0) begin
          w = 1; t = e0 + n + 1; stop = 0;
          while (stop == 0) begin
            if (t >= NE || rst_low[t]) stop = 2;
            else if (eff(1, t)) begin w++; t++; end
            else stop = 1;
          end
        end
        for (int j = e0; j < t && j < NE; j++) put(d, j, 1, 0, od, ow, ot);
        if (stop == 1) begin
          if (n > 0) begin od = n; ow = (w > maxv) ? maxv : w; ot = 0; end
          else begin od = tmo; ow = 0; ot = 1; end
          put(d, t, 0, 1, od, ow, ot);
          e = t + 1;
          skip = 1;
        end else begin
          e = t;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int e, input logic [31:0] got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, got, want);
    end
  endtask

  task automatic check_dut(input int d, input int e, input logic b, input logic dn,
                           input logic t, input logic [31:0] dl, input logic [31:0] wd);
    cmp($sformatf("dut%0d busy", d), e, 32'(b), int'(exp_busy[d][e]));
    cmp($sformatf("dut%0d done", d), e, 32'(dn), int'(exp_done[d][e]));
    cmp($sformatf("dut%0d timeout_flag", d), e, 32'(t), int'(exp_to[d][e]));
    cmp($sformatf("dut%0d delay_out", d), e, dl, exp_dly[d][e]);
    cmp($sformatf("dut%0d width_out", d), e, wd, exp_wid[d][e]);
    if (exp_done[d][e])
      $display("dut%0d edge %0d: done delay=%0d width=%0d timeout=%0d (dut delay=%0d width=%0d)",
               d, e, exp_dly[d][e], exp_wid[d][e], exp_to[d][e], dl, wd);
  endtask

  task automatic set_start(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) raw_start[i] = 1'b1;
  endtask

  task automatic set_sig(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) raw_sig[i] = 1'b1;
  endtask

  initial begin
    int sr, ss, cnt;
    bit sv;

    reset = 1'b0; start_in = 1'b0; sig_in = 1'b0;

    // Directed scenarios
    for (int i = 0; i < 4; i++) rst_low[i] = 1'b1;
    set_start(10, 12);  set_sig(20, 20);                       // basic
    set_start(40, 42);                                         // timeout
    set_sig(290, 302);  set_start(300, 302); set_sig(307, 310); // pre-high
    set_start(400, 402); set_sig(405, 444);                    // long pulse
    set_start(500, 501); set_start(505, 506); set_sig(512, 514); // retrigger
    set_start(600, 601); rst_low[604] = 1'b1; set_sig(610, 612); // reset abort
    set_start(650, 651); set_sig(655, 657);                    // recovery

    // Random region, then a quiet tail so every measurement completes
    sr = 0; ss = 0; sv = 1'b0;
    for (int e = 700; e < 3700; e++) begin
      if (sr > 0) begin
        raw_start[e] = 1'b1;
        sr--;
      end else if ($urandom_range(0, 24) == 0) begin
        sr = $urandom_range(1, 3);
      end
      if (ss == 0) begin
        sv = !sv;
        ss = sv ? $urandom_range(1, 25) : $urandom_range(1, 60);
      end
      raw_sig[e] = sv;
      ss--;
      rst_low[e] = ($urandom_range(0, 599) == 0);
    end

    run_model(0, 8, 200);
    run_model(1, 4, 12);

    pins.push_back('{0, 21 + LAT, 10, 1, 0});
    pins.push_back('{1, 21 + LAT, 10, 1, 0});
    pins.push_back('{0, 240 + LAT, 200, 0, 1});
    pins.push_back('{1, 52 + LAT, 12, 0, 1});
    pins.push_back('{0, 311 + LAT, 7, 4, 0});
    pins.push_back('{1, 311 + LAT, 7, 4, 0});
    pins.push_back('{0, 445 + LAT, 5, 40, 0});
    pins.push_back('{1, 445 + LAT, 5, 15, 0});
    pins.push_back('{0, 515 + LAT, 12, 3, 0});
    pins.push_back('{1, 515 + LAT, 12, 3, 0});
    pins.push_back('{0, 658 + LAT, 5, 3, 0});
    pins.push_back('{1, 658 + LAT, 5, 3, 0});

    // Pin the model itself to hand-derived results
    foreach (pins[i]) begin
      cmp("model done", pins[i].e, 32'(exp_done[pins[i].d][pins[i].e]), 1);
      cmp("model delay", pins[i].e, exp_dly[pins[i].d][pins[i].e], pins[i].dly);
      cmp("model width", pins[i].e, exp_wid[pins[i].d][pins[i].e], pins[i].wid);
      cmp("model timeout", pins[i].e, 32'(exp_to[pins[i].d][pins[i].e]), pins[i].to);
    end
    cnt = 0;
    for (int e = 500; e < 600; e++) cnt += int'(exp_done[0][e]);
    cmp("model retrigger done count", 500, cnt, 1);
    cnt = 0;
    for (int e = 600; e < 650; e++) cnt += int'(exp_done[0][e]) + int'(exp_done[1][e]);
    cmp("model abort done count", 600, cnt, 0);

    for (int e = 0; e < NE; e++) begin
      @(negedge clk);
      reset    = !rst_low[e];
      start_in = raw_start[e];
      sig_in   = raw_sig[e];
      @(posedge clk);
      #1;
      check_dut(0, e, busy0, done0, to0, 32'(dly0), 32'(wid0));
      check_dut(1, e, busy1, done1, to1, 32'(dly1), 32'(wid1));
      foreach (pins[i]) begin
        if (pins[i].e == e) begin
          if (pins[i].d == 0) begin
            cmp("pin done", e, 32'(done0), 1);
            cmp("pin delay", e, 32'(dly0), pins[i].dly);
            cmp("pin width", e, 32'(wid0), pins[i].wid);
            cmp("pin timeout", e, 32'(to0), pins[i].to);
          end else begin
            cmp("pin done", e, 32'(done1), 1);
            cmp("pin delay", e, 32'(dly1), pins[i].dly);
            cmp("pin width", e, 32'(wid1), pins[i].wid);
            cmp("pin timeout", e, 32'(to1), pins[i].to);
          end
        end
      end
      if (e == 2 || e == 604) begin
        cmp("reset busy", e, 32'(busy0), 0);
        cmp("reset done", e, 32'(done0), 0);
        cmp("reset timeout_flag", e, 32'(to0), 0);
        cmp("reset delay_out", e, 32'(dly0), 0);
        cmp("reset width_out", e, 32'(wid0), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
